mem_access_sched: RTL and testbench

Single-port scheduler for the tag's SRAM macro; sits between the protocol core, the ADC sensor logger and the factory-reset logic inside the tag top level. Arbitrates three requesters, sequences each macro access (precharge, word-line/address, write or sense, recovery), and drives `PC_B`, `WE`, `SE`, `mem_address`, `mem_sel` and `mem_data_out`. Buffers sensor samples in a 2-entry FIFO, logs them into a wrap-around ring in a dedicated bank, and performs a full-array zero sweep on factory reset.

---
 rtl/mem_access_sched.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sched.sv
// Single-port SRAM scheduler: protocol, sensor-log ring and factory-clear sweep share one 4-cycle access FSM.
// Protocol holds p_req until p_ack; sensor samples are dropped (sticky overflow) when the 2-entry FIFO is full.
module mem_access_sched #(
   parameter logic [2:0] SENS_SEL   = 3'd7,
   parameter logic [5:0] SENS_BASE  = 6'd0,
   parameter int         SENS_DEPTH = 32
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_p_req,
   input  logic        i_p_we,
   input  logic [5:0]  i_p_addr,
   input  logic [2:0]  i_p_sel,
   input  logic [15:0] i_p_wdata,
   output logic        o_p_ack,
   output logic [15:0] o_p_rdata,
   input  logic        i_s_valid,
   input  logic [7:0]  i_s_data,
   input  logic [7:0]  i_s_stamp,
   output logic        o_s_overflow,
   output logic [5:0]  o_s_wptr,
   input  logic        i_f_start,
   output logic        o_f_busy,
   input  logic [15:0] i_mem_read_in,
   output logic [15:0] o_mem_data_out,
   output logic [5:0]  o_mem_address,
   output logic [2:0]  o_mem_sel,
   output logic        o_pc_b,
   output logic        o_we,
   output logic        o_se
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_ACT, ST_REC} state_t;
   typedef enum logic [1:0] {OWN_P, OWN_S, OWN_C} own_t;

   localparam logic [5:0] LP_LAST = SENS_BASE + 6'(SENS_DEPTH - 1);

   state_t      r_state;
   own_t        r_own;
   logic        r_wr;
   logic        r_pc_b;
   logic        r_we;
   logic        r_se;
   logic [2:0]  r_mem_sel;
   logic [5:0]  r_mem_addr;
   logic [15:0] r_mem_data;
   logic        r_p_ack;
   logic [15:0] r_p_rdata;
   logic        r_ovf;
   logic [5:0]  r_wptr;
   logic        r_f_busy;
   logic        r_pend;
   logic [8:0]  r_clr_cnt;
   logic [15:0] r_fifo0;
   logic [15:0] r_fifo1;
   logic [1:0]  r_cnt;

   logic        w_idle;
   logic        w_enter_clr;
   logic        w_gnt_c;
   logic        w_gnt_s;
   logic        w_gnt_p;
   logic        w_accept;
   logic        w_push;
   logic        w_drop;
   logic [15:0] w_word;
   logic [5:0]  w_wptr_nxt;

   always_comb begin
      w_idle      = (r_state == ST_IDLE);
      // The IDLE cycle that starts a clear grants nothing; the sweep begins one cycle later.
      w_enter_clr = w_idle && r_pend && !r_f_busy;
      w_gnt_c     = w_idle && r_f_busy;
      w_gnt_s     = w_idle && !r_f_busy && !r_pend &&
                    ((r_cnt == 2'd2) || (!i_p_req && (r_cnt != 2'd0)));
      w_gnt_p     = w_idle && !r_f_busy && !r_pend && i_p_req && (r_cnt != 2'd2);
      w_accept    = i_s_valid && !r_f_busy && !w_enter_clr;
      w_push      = w_accept && ((r_cnt != 2'd2) || w_gnt_s);
      w_drop      = w_accept && !w_push;
      w_word      = {i_s_stamp, i_s_data};
      w_wptr_nxt  = (r_wptr == LP_LAST) ? SENS_BASE : r_wptr + 6'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_own      <= OWN_P;
         r_wr       <= 1'b0;
         r_pc_b     <= 1'b0;
         r_we       <= 1'b0;
         r_se       <= 1'b0;
         r_mem_sel  <= 3'd0;
         r_mem_addr <= 6'd0;
         r_mem_data <= 16'h0000;
         r_p_ack    <= 1'b0;
         r_p_rdata  <= 16'h0000;
         r_ovf      <= 1'b0;
         r_wptr     <= SENS_BASE;
         r_f_busy   <= 1'b0;
         r_pend     <= 1'b0;
         r_clr_cnt  <= 9'd0;
         r_fifo0    <= 16'h0000;
         r_fifo1    <= 16'h0000;
         r_cnt      <= 2'd0;
      end else begin
         if (i_f_start && !r_f_busy && !w_enter_clr)
            r_pend <= 1'b1;

         if (w_enter_clr) begin
            r_f_busy  <= 1'b1;
            r_pend    <= 1'b0;
            r_cnt     <= 2'd0;
            r_ovf     <= 1'b0;
            r_wptr    <= SENS_BASE;
            r_clr_cnt <= 9'd0;
         end else begin
            if (w_drop)
               r_ovf <= 1'b1;
            if (w_gnt_s && w_push) begin
               if (r_cnt == 2'd1) begin
                  r_fifo0 <= w_word;
               end else begin
                  r_fifo0 <= r_fifo1;
                  r_fifo1 <= w_word;
               end
            end else if (w_gnt_s) begin
               r_fifo0 <= r_fifo1;
               r_cnt   <= r_cnt - 2'd1;
            end else if (w_push) begin
               if (r_cnt == 2'd0)
                  r_fifo0 <= w_word;
               else
                  r_fifo1 <= w_word;
               r_cnt <= r_cnt + 2'd1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_gnt_c) begin
                  r_state    <= ST_ADDR;
                  r_pc_b     <= 1'b1;
                  r_own      <= OWN_C;
                  r_wr       <= 1'b1;
                  r_mem_sel  <= r_clr_cnt[8:6];
                  r_mem_addr <= r_clr_cnt[5:0];
                  r_mem_data <= 16'h0000;
                  r_clr_cnt  <= r_clr_cnt + 9'd1;
               end else if (w_gnt_s) begin
                  r_state    <= ST_ADDR;
                  r_pc_b     <= 1'b1;
                  r_own      <= OWN_S;
                  r_wr       <= 1'b1;
                  r_mem_sel  <= SENS_SEL;
                  r_mem_addr <= r_wptr;
                  r_mem_data <= r_fifo0;
               end else if (w_gnt_p) begin
                  r_state    <= ST_ADDR;
                  r_pc_b     <= 1'b1;
                  r_own      <= OWN_P;
                  r_wr       <= i_p_we;
                  r_mem_sel  <= i_p_sel;
                  r_mem_addr <= i_p_addr;
                  r_mem_data <= i_p_wdata;
               end
            end
            ST_ADDR: begin
               r_state <= ST_ACT;
               r_we    <= r_wr;
               r_se    <= !r_wr;
            end
            ST_ACT: begin
               r_state <= ST_REC;
               r_we    <= 1'b0;
               r_se    <= 1'b0;
               if (r_own == OWN_P) begin
                  r_p_ack <= 1'b1;
                  if (!r_wr)
                     r_p_rdata <= i_mem_read_in;
               end
               if (r_own == OWN_S)
                  r_wptr <= w_wptr_nxt;
            end
            ST_REC: begin
               r_state <= ST_IDLE;
               r_pc_b  <= 1'b0;
               r_p_ack <= 1'b0;
               // Counter wraps to zero only after the 512th sweep grant.
               if (r_own == OWN_C && r_clr_cnt == 9'd0)
                  r_f_busy <= 1'b0;
            end
         endcase
      end
   end

   assign o_p_ack        = r_p_ack;
   assign o_p_rdata      = r_p_rdata;
   assign o_s_overflow   = r_ovf;
   assign o_s_wptr       = r_wptr;
   assign o_f_busy       = r_f_busy;
   assign o_mem_data_out = r_mem_data;
   assign o_mem_address  = r_mem_addr;
   assign o_mem_sel      = r_mem_sel;
   assign o_pc_b         = r_pc_b;
   assign o_we           = r_we;
   assign o_se           = r_se;

endmodule

// File: tb/tb_mem_access_sched.sv
// Bench for mem_access_sched: SRAM macro model, queue-based scheduling model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_access_sched;

   localparam int SB    = 0;
   localparam int DEPTH = 32;

   logic        clk;
   logic        i_reset;
   logic        i_p_req;
   logic        i_p_we;
   logic [5:0]  i_p_addr;
   logic [2:0]  i_p_sel;
   logic [15:0] i_p_wdata;
   logic        o_p_ack;
   logic [15:0] o_p_rdata;
   logic        i_s_valid;
   logic [7:0]  i_s_data;
   logic [7:0]  i_s_stamp;
   logic        o_s_overflow;
   logic [5:0]  o_s_wptr;
   logic        i_f_start;
   logic        o_f_busy;
   logic [15:0] mem_read_in;
   logic [15:0] o_mem_data_out;
   logic [5:0]  o_mem_address;
   logic [2:0]  o_mem_sel;
   logic        o_pc_b;
   logic        o_we;
   logic        o_se;

   int checks   = 0;
   int failures = 0;

   logic [15:0] sram [512];

   mem_access_sched #(.SENS_SEL(3'd7), .SENS_BASE(6'd0), .SENS_DEPTH(32)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_p_req(i_p_req), .i_p_we(i_p_we), .i_p_addr(i_p_addr), .i_p_sel(i_p_sel),
      .i_p_wdata(i_p_wdata), .o_p_ack(o_p_ack), .o_p_rdata(o_p_rdata),
      .i_s_valid(i_s_valid), .i_s_data(i_s_data), .i_s_stamp(i_s_stamp),
      .o_s_overflow(o_s_overflow), .o_s_wptr(o_s_wptr),
      .i_f_start(i_f_start), .o_f_busy(o_f_busy),
      .i_mem_read_in(mem_read_in), .o_mem_data_out(o_mem_data_out),
      .o_mem_address(o_mem_address), .o_mem_sel(o_mem_sel),
      .o_pc_b(o_pc_b), .o_we(o_we), .o_se(o_se)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] init_val(input int i);
      return 16'(i * 40503 + 4660);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM macro: writes on any edge with WE high, drives read data only while sensing.
   assign mem_read_in = o_se ? sram[{o_mem_sel, o_mem_address}] : 16'hBAD0;
   initial begin
      for (int i = 0; i < 512; i++) sram[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (o_we) sram[{o_mem_sel, o_mem_address}] <= o_mem_data_out;
      end
   end

   // Behavioural model: one access occupies phases 0..3, requests arbitrated at phase 0.
   logic [15:0] m_mem [512];
   logic [15:0] q[$];
   int          m_ph, m_own, m_wptr, m_clr;
   bit          m_we, m_ovf, m_pend, m_busy, m_valid;
   logic [2:0]  m_sel;
   logic [5:0]  m_addr;
   logic [15:0] m_data, m_rdata;

   initial begin
      bit enter, busy_old;
      m_valid = 0;
      for (int i = 0; i < 512; i++) m_mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (i_reset) begin
            if (m_ph == 2 && m_we) m_mem[{m_sel, m_addr}] = m_data;
            m_ph = 0; m_own = 0; m_we = 0; m_sel = 0; m_addr = 0; m_data = 0;
            m_rdata = 0; m_ovf = 0; m_wptr = SB; m_pend = 0; m_busy = 0; m_clr = 0;
            q.delete();
            m_valid = 1;
         end else begin
            busy_old = m_busy;
            enter    = (m_ph == 0) && m_pend && !m_busy;
            if (m_ph == 0 && !enter) begin
               if (m_busy) begin
                  m_own = 2; m_we = 1; m_sel = 3'(m_clr / 64); m_addr = 6'(m_clr % 64);
                  m_data = 0; m_clr++; m_ph = 1;
               end else if (q.size() == 2 || (q.size() > 0 && !i_p_req)) begin
                  m_own = 1; m_we = 1; m_sel = 3'd7; m_addr = 6'(m_wptr);
                  m_data = q.pop_front(); m_ph = 1;
               end else if (i_p_req) begin
                  m_own = 0; m_we = i_p_we; m_sel = i_p_sel; m_addr = i_p_addr;
                  m_data = i_p_wdata; m_ph = 1;
               end
            end else if (m_ph == 1) begin
               m_ph = 2;
            end else if (m_ph == 2) begin
               if (m_we) m_mem[{m_sel, m_addr}] = m_data;
               else if (m_own == 0) m_rdata = m_mem[{m_sel, m_addr}];
               if (m_own == 1) m_wptr = (m_wptr - SB + 1) % DEPTH + SB;
               m_ph = 3;
            end else if (m_ph == 3) begin
               m_ph = 0;
               if (m_own == 2 && m_clr == 512) m_busy = 0;
            end
            if (enter) begin
               m_busy = 1; m_pend = 0; q.delete(); m_ovf = 0; m_wptr = SB; m_clr = 0;
            end else if (i_s_valid && !busy_old) begin
               if (q.size() < 2) q.push_back({i_s_stamp, i_s_data});
               else m_ovf = 1;
            end
            if (i_f_start && !busy_old && !enter) m_pend = 1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid)
            chk("outputs",
                64'({o_pc_b, o_we, o_se, o_mem_sel, o_mem_address, o_mem_data_out,
                     o_p_ack, o_p_rdata, o_s_overflow, o_s_wptr, o_f_busy}),
                64'({m_ph != 0, m_ph == 2 && m_we, m_ph == 2 && !m_we, m_sel, m_addr, m_data,
                     m_ph == 3 && m_own == 0, m_rdata, m_ovf, 6'(m_wptr), m_busy}));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic proto(input logic we, input logic [2:0] sel, input logic [5:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_rd);
      i_p_req = 1; i_p_we = we; i_p_sel = sel; i_p_addr = addr; i_p_wdata = wd;
      tick();
      chk("addr_phase", 64'({o_pc_b, o_we, o_se, o_mem_sel, o_mem_address}), 64'({3'b100, sel, addr}));
      tick();
      chk("act_phase", 64'({o_we, o_se}), we ? 64'd2 : 64'd1);
      tick();
      chk("rec_phase", 64'({o_p_ack, o_we, o_se, o_pc_b}), 64'b1001);
      if (!we) chk("p_rdata", 64'(o_p_rdata), 64'(exp_rd));
      i_p_req = 0;
      tick();
      chk("idle_phase", 64'({o_p_ack, o_pc_b}), 64'd0);
   endtask

   task automatic wait_ack(input int budget);
      for (int k = 0; k < budget && !o_p_ack; k++) tick();
      chk("ack_seen", 64'(o_p_ack), 64'd1);
   endtask

   initial begin
      int cnt, nz;
      bit got;
      i_reset = 1; i_p_req = 0; i_p_we = 0; i_p_addr = 0; i_p_sel = 0; i_p_wdata = 0;
      i_s_valid = 0; i_s_data = 0; i_s_stamp = 0; i_f_start = 0;
      tick(); tick();
      i_reset = 0;
      chk("rst_ctrl", 64'({o_pc_b, o_we, o_se, o_p_ack, o_f_busy, o_s_overflow}), 64'd0);
      chk("rst_addr", 64'({o_mem_sel, o_mem_address, o_mem_data_out}), 64'd0);
      chk("rst_rdata", 64'(o_p_rdata), 64'd0);
      chk("rst_wptr", 64'(o_s_wptr), 64'd0);

      // Protocol write then read back.
      proto(1'b1, 3'd2, 6'h11, 16'hA5C3, 16'h0000);
      proto(1'b0, 3'd2, 6'h11, 16'h0000, 16'hA5C3);

      // Protocol and sample in the same IDLE: protocol first, sample next.
      i_p_req = 1; i_p_we = 1; i_p_sel = 3'd1; i_p_addr = 6'd5; i_p_wdata = 16'h1234;
      i_s_valid = 1; i_s_data = 8'h7E; i_s_stamp = 8'h3C;
      tick();
      i_s_valid = 0;
      chk("proto_first", 64'(o_mem_sel), 64'd1);
      tick(); tick();
      chk("proto_ack", 64'(o_p_ack), 64'd1);
      i_p_req = 0;
      tick(); tick();
      chk("sensor_next", 64'({o_mem_sel, o_mem_address, o_mem_data_out}), 64'({3'd7, 6'd0, 16'h3C7E}));
      tick(); tick();
      chk("wptr_one", 64'(o_s_wptr), 64'd1);
      tick();
      chk("sram_sensor", 64'(sram[7*64]), 64'h3C7E);

      // Ring wrap: 33 samples from a fresh pointer.
      i_reset = 1; tick(); i_reset = 0;
      for (int i = 0; i < 33; i++) begin
         i_s_valid = 1; i_s_data = 8'(i) ^ 8'h5A; i_s_stamp = 8'(i + 8'h40);
         tick();
         i_s_valid = 0;
         tick(); tick(); tick();
      end
      repeat (8) tick();
      chk("wrap_addr0", 64'(sram[7*64]), 64'h607A);
      chk("wrap_addr31", 64'(sram[7*64 + 31]), 64'h5F45);
      chk("wrap_wptr", 64'(o_s_wptr), 64'd1);
      chk("wrap_ovf", 64'(o_s_overflow), 64'd0);

      // Held protocol request plus three back-to-back samples.
      i_p_req = 1; i_p_we = 0; i_p_sel = 3'd1; i_p_addr = 6'd5;
      i_s_valid = 1; i_s_data = 8'h01; i_s_stamp = 8'h11;
      tick();
      i_s_data = 8'h02;
      tick();
      i_s_data = 8'h03;
      tick();
      i_s_valid = 0;
      chk("held_ack", 64'(o_p_ack), 64'd1);
      chk("held_rdata", 64'(o_p_rdata), 64'h1234);
      chk("ovf_set", 64'(o_s_overflow), 64'd1);
      tick(); tick();
      chk("full_sensor_wins", 64'({o_mem_sel, o_mem_data_out}), 64'({3'd7, 16'h1101}));
      repeat (4) tick();
      chk("proto_over_nonempty", 64'(o_mem_sel), 64'd1);
      tick(); tick();
      chk("held_ack2", 64'(o_p_ack), 64'd1);
      i_p_req = 0;
      repeat (6) tick();

      // Factory clear requested during a protocol ACT.
      i_p_req = 1; i_p_we = 1; i_p_sel = 3'd3; i_p_addr = 6'd9; i_p_wdata = 16'hBEEF;
      tick(); tick();
      i_f_start = 1;
      tick();
      i_f_start = 0;
      chk("clr_proto_ack", 64'(o_p_ack), 64'd1);
      i_p_req = 0;
      tick();
      chk("busy_not_yet", 64'(o_f_busy), 64'd0);
      tick();
      chk("busy_rise", 64'({o_f_busy, o_s_overflow, o_s_wptr}), 64'({1'b1, 1'b0, 6'd0}));
      cnt = 0; got = 0;
      while (o_f_busy && cnt < 3000) begin
         if (cnt == 100) begin
            i_p_req = 1; i_p_we = 0; i_p_sel = 3'd0; i_p_addr = 6'd3; i_s_valid = 1;
         end
         if (cnt == 101) i_s_valid = 0;
         got |= o_p_ack;
         cnt++;
         tick();
      end
      chk("clr_len", 64'(cnt), 64'd2048);
      chk("clr_noack", 64'(got), 64'd0);
      chk("clr_ovf", 64'(o_s_overflow), 64'd0);
      wait_ack(20);
      chk("clr_read0", 64'(o_p_rdata), 64'd0);
      i_p_req = 0;
      tick();
      nz = 0;
      for (int i = 0; i < 512; i++) if (sram[i] != 16'h0000) nz++;
      chk("sram_zero", 64'(nz), 64'd0);

      // Reset during the ACT of a write.
      i_p_req = 1; i_p_we = 1; i_p_sel = 3'd4; i_p_addr = 6'd20; i_p_wdata = 16'h5555;
      tick(); tick();
      chk("rst_act_we", 64'(o_we), 64'd1);
      i_reset = 1;
      tick();
      i_reset = 0; i_p_req = 0;
      chk("rst_mid", 64'({o_pc_b, o_we, o_se, o_mem_sel, o_mem_address, o_mem_data_out,
                         o_p_ack, o_p_rdata, o_s_overflow, o_s_wptr, o_f_busy}), 64'd0);
      got = 0;
      repeat (8) begin
         tick();
         got |= o_p_ack;
      end
      chk("rst_noack", 64'(got), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
